pixel_timing_ctrl: RTL and testbench

PIXEL_TIMING_CTRL -- requirements
Module: pixel_timing_ctrl

---
 rtl/pixel_pkg.sv | 29 ++
 rtl/pixel_timing_ctrl_if.sv | 27 ++
 rtl/pixel_axis_cnt.sv | 56 +++++
 rtl/pixel_timing_ctrl.sv | 135 +++++++++++++
 tb/tb_pixel_timing_ctrl.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/pixel_pkg.sv
// Shared types and default timing for the pixel timing controller.
package pixel_pkg;

  localparam int unsigned PIXEL_W = 24;

  typedef logic [PIXEL_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // 640x480 @ 60 Hz style defaults
  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  // Counter width for a 0..total-1 count; never narrower than one bit
  function automatic int unsigned cnt_width(input int unsigned total);
    return (total > 1) ? $clog2(total) : 1;
  endfunction

endpackage

// File: rtl/pixel_timing_ctrl_if.sv
// Source handshake and pixel-interface bundle of the timing controller.
interface pixel_timing_ctrl_if;
  import pixel_pkg::*;

  pixel_t src_pixel;
  logic   src_valid;
  logic   src_ready;
  logic   hsync;
  logic   vsync;
  pixel_t pixel_data;
  logic   data_valid;
  logic   frame_start;
  logic   underflow;

  // Controller side
  modport master (
    input  src_pixel, src_valid,
    output src_ready, hsync, vsync, pixel_data, data_valid, frame_start, underflow
  );

  // Source / display side
  modport slave (
    output src_pixel, src_valid,
    input  src_ready, hsync, vsync, pixel_data, data_valid, frame_start, underflow
  );

endinterface

// File: rtl/pixel_axis_cnt.sv
// One timing axis: wrapping position counter plus region decode.
module pixel_axis_cnt
  import pixel_pkg::*;
#(
  parameter int unsigned ACTIVE = 4,
  parameter int unsigned FP     = 1,
  parameter int unsigned SYNC   = 2,
  parameter int unsigned BP     = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic adv_i,
  output logic zero_c_o,
  output logic last_c_o,
  output logic active_c_o,
  output logic sync_c_o
);

  localparam int unsigned TOTAL = ACTIVE + FP + SYNC + BP;
  localparam int unsigned W     = cnt_width(TOTAL);

  localparam logic [W-1:0] LAST_POS   = W'(TOTAL - 1);
  localparam logic [W-1:0] ACT_END    = W'(ACTIVE);
  localparam logic [W-1:0] SYNC_START = W'(ACTIVE + FP);
  localparam logic [W-1:0] SYNC_END   = W'(ACTIVE + FP + SYNC);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Region decode of the current position
  assign zero_c_o   = (cnt_q == '0);
  assign last_c_o   = (cnt_q == LAST_POS);
  assign active_c_o = (cnt_q < ACT_END);
  assign sync_c_o   = (cnt_q >= SYNC_START) && (cnt_q < SYNC_END);

  // Next position: clear wins, otherwise advance and wrap at the last position
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (adv_i) begin
      cnt_d = last_c_o ? '0 : cnt_q + W'(1);
    end
  end

  // Position register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pixel_timing_ctrl.sv
// Raster timing engine: pulls pixels from a source and drives sync/data outputs.
module pixel_timing_ctrl
  import pixel_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  pixel_timing_ctrl_if.master bus
);

  state_e state_q, state_d;

  logic   run_c;
  logic   src_ready_c;
  logic   h_zero_c, h_last_c, h_active_c, h_sync_c;
  logic   v_zero_c, v_last_c, v_active_c, v_sync_c;

  logic   hsync_q, hsync_d;
  logic   vsync_q, vsync_d;
  pixel_t pixel_data_q, pixel_data_d;
  logic   data_valid_q, data_valid_d;
  logic   frame_start_q, frame_start_d;
  logic   underflow_q, underflow_d;

  // Counters hold at zero in IDLE and free-run otherwise
  assign run_c = (state_q != ST_IDLE);

  pixel_axis_cnt #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (!run_c),
    .adv_i      (run_c),
    .zero_c_o   (h_zero_c),
    .last_c_o   (h_last_c),
    .active_c_o (h_active_c),
    .sync_c_o   (h_sync_c)
  );

  pixel_axis_cnt #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (!run_c),
    .adv_i      (run_c && h_last_c),
    .zero_c_o   (v_zero_c),
    .last_c_o   (v_last_c),
    .active_c_o (v_active_c),
    .sync_c_o   (v_sync_c)
  );

  // Next state and next values of the registered pixel-interface outputs
  always_comb begin
    state_d       = state_q;
    src_ready_c   = 1'b0;
    hsync_d       = 1'b0;
    vsync_d       = 1'b0;
    data_valid_d  = 1'b0;
    pixel_data_d  = '0;
    frame_start_d = 1'b0;
    underflow_d   = underflow_q;

    case (state_q)
      ST_IDLE:  if (enable) state_d = ST_RUN;
      ST_RUN:   if (!enable) state_d = ST_DRAIN;
      ST_DRAIN: begin
        // A drained frame always runs to its last pixel before stopping
        if (enable) begin
          state_d = ST_RUN;
        end else if (h_last_c && v_last_c) begin
          state_d = ST_IDLE;
        end
      end
      default:  state_d = ST_IDLE;
    endcase

    if (run_c) begin
      src_ready_c = h_active_c && v_active_c;
      hsync_d     = h_sync_c;
      vsync_d     = v_sync_c;
    end

    data_valid_d  = src_ready_c;
    pixel_data_d  = (src_ready_c && bus.src_valid) ? bus.src_pixel : '0;
    frame_start_d = src_ready_c && h_zero_c && v_zero_c;
    underflow_d   = underflow_q | (src_ready_c & ~bus.src_valid);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      pixel_data_q  <= '0;
      data_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      pixel_data_q  <= pixel_data_d;
      data_valid_q  <= data_valid_d;
      frame_start_q <= frame_start_d;
      underflow_q   <= underflow_d;
    end
  end

  assign bus.src_ready   = src_ready_c;
  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.pixel_data  = pixel_data_q;
  assign bus.data_valid  = data_valid_q;
  assign bus.frame_start = frame_start_q;
  assign bus.underflow   = underflow_q;

endmodule

// File: tb/tb_pixel_timing_ctrl.sv
// Bench for pixel_timing_ctrl on a tiny 8x6 raster against a frame-position model.
`timescale 1ns/1ps
module tb_pixel_timing_ctrl;
  import pixel_pkg::*;

  localparam int HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic clk = 1'b0;
  logic rst_n;
  logic enable;

  pixel_timing_ctrl_if bus();

  pixel_timing_ctrl #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: engine running flag, drain request, position within the frame
  bit     m_run, m_drain, m_uf;
  int     m_pos;
  logic   e_hs, e_vs, e_dv, e_fs, e_uf;
  pixel_t e_pix;

  int cyc, n_dv, n_hs, n_vs, n_fs, fs_a, fs_b;
  pixel_t pix_ctr;
  bit     en_r;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_drain = 0; m_uf = 0; m_pos = 0;
    e_hs = 0; e_vs = 0; e_dv = 0; e_fs = 0; e_uf = 0; e_pix = '0;
  endtask

  task automatic clear_stats();
    cyc = 0; n_dv = 0; n_hs = 0; n_vs = 0; n_fs = 0; fs_a = -1; fs_b = -1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ready"}, bus.src_ready, 1'b0);
    check_eq({tag, "_hsync"}, bus.hsync, 1'b0);
    check_eq({tag, "_vsync"}, bus.vsync, 1'b0);
    check_eq({tag, "_pix"}, bus.pixel_data, 24'h0);
    check_eq({tag, "_dv"}, bus.data_valid, 1'b0);
    check_eq({tag, "_fs"}, bus.frame_start, 1'b0);
    check_eq({tag, "_uf"}, bus.underflow, 1'b0);
  endtask

  // Enters and leaves at a falling edge with reset released
  task automatic do_reset();
    rst_n = 1'b0; enable = 1'b0; bus.src_valid = 1'b0; bus.src_pixel = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all_zero("rst");
    rst_n = 1'b1;
    clear_stats();
  endtask

  // One clock: drive, check combinational ready, advance model, check outputs
  task automatic step(input bit en, input bit val, input pixel_t pix);
    int h, v;
    bit rdy, done;
    enable = en; bus.src_valid = val; bus.src_pixel = pix;
    #1;
    h   = m_pos % HT;
    v   = m_pos / HT;
    rdy = m_run && (h < HA) && (v < VA);
    check_eq("src_ready", bus.src_ready, rdy);
    e_dv  = rdy;
    e_pix = (rdy && val) ? pix : '0;
    e_hs  = m_run && (h >= HA + HF) && (h < HA + HF + HS);
    e_vs  = m_run && (v >= VA + VF) && (v < VA + VF + VS);
    e_fs  = rdy && (m_pos == 0);
    m_uf  = m_uf | (rdy && !val);
    e_uf  = m_uf;
    if (!m_run) begin
      if (en) begin m_run = 1; m_pos = 0; m_drain = 0; end
    end else begin
      done    = m_drain && !en && (m_pos == FT - 1);
      m_drain = !en;
      m_pos   = (m_pos + 1) % FT;
      if (done) begin m_run = 0; m_drain = 0; m_pos = 0; end
    end
    @(posedge clk);
    #1;
    check_eq("data_valid", bus.data_valid, e_dv);
    check_eq("pixel_data", bus.pixel_data, e_pix);
    check_eq("hsync", bus.hsync, e_hs);
    check_eq("vsync", bus.vsync, e_vs);
    check_eq("frame_start", bus.frame_start, e_fs);
    check_eq("underflow", bus.underflow, e_uf);
    if (bus.data_valid) n_dv++;
    if (bus.hsync) n_hs++;
    if (bus.vsync) n_vs++;
    if (bus.frame_start) begin
      n_fs++;
      if (fs_a < 0) fs_a = cyc;
      else if (fs_b < 0) fs_b = cyc;
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; bus.src_valid = 1'b0; bus.src_pixel = '0;
    model_reset();
    clear_stats();
    @(negedge clk);

    // Continuous streaming, incrementing pixels, two full frames
    do_reset();
    pix_ctr = 24'h000100;
    for (int i = 0; i < 1 + 2 * FT; i++) begin
      step(1'b1, 1'b1, pix_ctr);
      if (bus.data_valid) pix_ctr = pix_ctr + 24'd1;
    end
    check_eq("stream_dv_count", 32'(n_dv), 32'(2 * HA * VA));
    check_eq("stream_hs_count", 32'(n_hs), 32'(2 * HS * VT));
    check_eq("stream_vs_count", 32'(n_vs), 32'(2 * HT * VS));
    check_eq("stream_fs_period", 32'(fs_b - fs_a), 32'(FT));

    // Source starves on the second active pixel
    do_reset();
    for (int i = 0; i < 20; i++) step(1'b1, (i != 2), 24'hABC000 + 24'(i));
    check_eq("uf_sticky", bus.underflow, 1'b1);

    // Enable dropped mid-frame: the frame still completes, then silence
    do_reset();
    for (int i = 0; i < 11; i++) step(1'b1, 1'b1, 24'(i));
    for (int i = 0; i < 60; i++) step(1'b0, 1'b1, 24'(i));
    check_eq("drain_dv_count", 32'(n_dv), 32'(HA * VA));
    check_eq("drain_fs_count", 32'(n_fs), 32'd1);
    clear_stats();
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 24'hFFFFFF);
    check_eq("idle_quiet", 32'(n_dv + n_hs + n_vs + n_fs), 32'd0);

    // Enable dropped then restored: no gap between frames
    do_reset();
    for (int i = 0; i < 60; i++) step(!(i >= 11 && i <= 20), 1'b1, 24'(i * 3));
    check_eq("resume_fs_period", 32'(fs_b - fs_a), 32'(FT));

    // Asynchronous reset mid-frame, with underflow already set
    do_reset();
    for (int i = 0; i < 26; i++) step(1'b1, (i != 3), 24'h5A5A00 + 24'(i));
    check_eq("pre_rst_uf", bus.underflow, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    clear_stats();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 24'(i));
    check_eq("restart_fs_cycle", 32'(fs_a), 32'd1);

    // Random enable toggling, starving source and pixel data
    do_reset();
    en_r = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 39) == 0) en_r = ~en_r;
      step(en_r, ($urandom_range(0, 9) != 0), 24'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
